// File: rtl/riscv_cpu_core.sv
// riscv_cpu_core: 5-stage RV32I pipeline with internal
// instruction/data memories, forwarding and hazard control.
package riscv_pkg;
    typedef enum logic [3:0] {
        A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU, A_XOR,
        A_SRL, A_SRA, A_OR, A_AND, A_PASSB
    } alu_op_e;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        alu_op_e     op;
        logic        a_pc;
        logic        b_imm;
        logic        wen;
        logic        ld;
        logic        st;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
    } id_ex_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] sd;
        logic        wen;
        logic        ld;
        logic        st;
    } ex_mem_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
        logic        wen;
    } mem_wb_t;
endpackage

module riscv_cpu_core
    import riscv_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        r,
    input  logic        i_mem_write,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_data,
    input  logic [4:0]  dbg_reg_addr,
    output logic [31:0] dbg_reg_data,
    output logic [31:0] pc_out
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] rf_q [32];

    logic [31:0] pc_q, pc_d;
    if_id_t  ifid_q, ifid_d;
    id_ex_t  idex_q, idex_d, dec;
    ex_mem_t exmem_q, exmem_d;
    mem_wb_t memwb_q, memwb_d;

    logic [31:0] ins, rv1, rv2, f1, f2, opa, opb, alu, target;
    logic [6:0]  f7;
    logic        ok, use1, use2, lu, cond, taken, stall;
    logic        unused;

    assign unused = &{1'b0, i_mem_addr[31:IW+2], i_mem_addr[1:0]};
    assign pc_out = pc_q;
    assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? 32'd0 : rf_q[dbg_reg_addr];

    // ID: decode, immediates, bypassed register read
    always_comb begin
        ins = ifid_q.ins;
        f7 = ins[31:25];
        dec = '0;
        dec.pc = ifid_q.pc;
        dec.rs1 = ins[19:15];
        dec.rs2 = ins[24:20];
        dec.rd = ins[11:7];
        dec.f3 = ins[14:12];
        dec.op = A_ADD;
        ok = 1'b1;
        use1 = 1'b0;
        use2 = 1'b0;
        unique case (1'b1)
            ins[6:0] == 7'b0110111: begin
                dec.imm = {ins[31:12], 12'd0};
                dec.b_imm = 1'b1;
                dec.op = A_PASSB;
                dec.wen = 1'b1;
            end
            ins[6:0] == 7'b0010111: begin
                dec.imm = {ins[31:12], 12'd0};
                dec.a_pc = 1'b1;
                dec.b_imm = 1'b1;
                dec.wen = 1'b1;
            end
            ins[6:0] == 7'b1101111: begin
                dec.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
                dec.jal = 1'b1;
                dec.wen = 1'b1;
            end
            ins[6:0] == 7'b1100111: begin
                dec.imm = {{20{ins[31]}}, ins[31:20]};
                dec.jalr = 1'b1;
                dec.wen = 1'b1;
                use1 = 1'b1;
                ok = (dec.f3 == 3'b000);
            end
            ins[6:0] == 7'b1100011: begin
                dec.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                dec.br = 1'b1;
                use1 = 1'b1;
                use2 = 1'b1;
                ok = (dec.f3 != 3'b010) && (dec.f3 != 3'b011);
            end
            ins[6:0] == 7'b0000011: begin
                dec.imm = {{20{ins[31]}}, ins[31:20]};
                dec.b_imm = 1'b1;
                dec.ld = 1'b1;
                dec.wen = 1'b1;
                use1 = 1'b1;
                ok = (dec.f3 == 3'b010);
            end
            ins[6:0] == 7'b0100011: begin
                dec.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                dec.b_imm = 1'b1;
                dec.st = 1'b1;
                use1 = 1'b1;
                use2 = 1'b1;
                ok = (dec.f3 == 3'b010);
            end
            ins[6:0] == 7'b0010011,
            ins[6:0] == 7'b0110011: begin
                dec.imm = {{20{ins[31]}}, ins[31:20]};
                dec.b_imm = ~ins[5];
                dec.wen = 1'b1;
                use1 = 1'b1;
                use2 = ins[5];
                case (dec.f3)
                    3'b000: dec.op = (ins[5] && ins[30]) ? A_SUB : A_ADD;
                    3'b001: dec.op = A_SLL;
                    3'b010: dec.op = A_SLT;
                    3'b011: dec.op = A_SLTU;
                    3'b100: dec.op = A_XOR;
                    3'b101: dec.op = ins[30] ? A_SRA : A_SRL;
                    3'b110: dec.op = A_OR;
                    default: dec.op = A_AND;
                endcase
                if (ins[5] || dec.f3 == 3'b001 || dec.f3 == 3'b101) begin
                    ok = (f7 == 7'd0) || (f7 == 7'b0100000 &&
                         (dec.f3 == 3'b101 || (ins[5] && dec.f3 == 3'b000)));
                end
            end
            default: ok = 1'b0;
        endcase
        if (!ok || !ifid_q.v) begin
            dec.wen = 1'b0;
            dec.ld = 1'b0;
            dec.st = 1'b0;
            dec.br = 1'b0;
            dec.jal = 1'b0;
            dec.jalr = 1'b0;
            use1 = 1'b0;
            use2 = 1'b0;
        end
        rv1 = rf_q[dec.rs1];
        rv2 = rf_q[dec.rs2];
        if (memwb_q.wen && memwb_q.rd == dec.rs1) rv1 = memwb_q.res;
        if (memwb_q.wen && memwb_q.rd == dec.rs2) rv2 = memwb_q.res;
        if (dec.rs1 == 5'd0) rv1 = 32'd0;
        if (dec.rs2 == 5'd0) rv2 = 32'd0;
        dec.a = rv1;
        dec.b = rv2;
        lu = idex_q.ld && idex_q.rd != 5'd0 &&
             ((use1 && dec.rs1 == idex_q.rd) || (use2 && dec.rs2 == idex_q.rd));
    end

    // EX: forwarding, ALU, branch resolution
    always_comb begin
        f1 = idex_q.a;
        f2 = idex_q.b;
        if (memwb_q.wen && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs1) f1 = memwb_q.res;
        if (memwb_q.wen && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs2) f2 = memwb_q.res;
        if (exmem_q.wen && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs1) f1 = exmem_q.res;
        if (exmem_q.wen && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs2) f2 = exmem_q.res;
        opa = idex_q.a_pc ? idex_q.pc : f1;
        opb = idex_q.b_imm ? idex_q.imm : f2;
        case (idex_q.op)
            A_SUB:   alu = opa - opb;
            A_SLL:   alu = opa << opb[4:0];
            A_SLT:   alu = {31'd0, $signed(opa) < $signed(opb)};
            A_SLTU:  alu = {31'd0, opa < opb};
            A_XOR:   alu = opa ^ opb;
            A_SRL:   alu = opa >> opb[4:0];
            A_SRA:   alu = $signed(opa) >>> opb[4:0];
            A_OR:    alu = opa | opb;
            A_AND:   alu = opa & opb;
            A_PASSB: alu = opb;
            default: alu = opa + opb;
        endcase
        case (idex_q.f3)
            3'b000:  cond = (f1 == f2);
            3'b001:  cond = (f1 != f2);
            3'b100:  cond = $signed(f1) < $signed(f2);
            3'b101:  cond = $signed(f1) >= $signed(f2);
            3'b110:  cond = f1 < f2;
            3'b111:  cond = f1 >= f2;
            default: cond = 1'b0;
        endcase
        taken = idex_q.jal || idex_q.jalr || (idex_q.br && cond);
        target = idex_q.jalr ? ((f1 + idex_q.imm) & ~32'd1) : (idex_q.pc + idex_q.imm);
        stall = lu && !taken;
        exmem_d.rd = idex_q.rd;
        exmem_d.res = (idex_q.jal || idex_q.jalr) ? idex_q.pc + 32'd4 : alu;
        exmem_d.sd = f2;
        exmem_d.wen = idex_q.wen;
        exmem_d.ld = idex_q.ld;
        exmem_d.st = idex_q.st;
    end

    // IF next PC and pipeline advance with flush over stall
    always_comb begin
        pc_d = taken ? target : (stall ? pc_q : pc_q + 32'd4);
        ifid_d.v = 1'b1;
        ifid_d.pc = pc_q;
        ifid_d.ins = imem[pc_q[IW+1:2]];
        if (stall) ifid_d = ifid_q;
        if (taken) ifid_d = '0;
        idex_d = (taken || stall) ? '0 : dec;
        memwb_d.rd = exmem_q.rd;
        memwb_d.wen = exmem_q.wen;
        memwb_d.res = exmem_q.ld ? dmem[exmem_q.res[DW+1:2]] : exmem_q.res;
    end

    // Pipeline state registers
    always_ff @(posedge clk) begin
        if (!r) begin
            pc_q <= 32'd0;
            ifid_q <= '0;
            idex_q <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            pc_q <= pc_d;
            ifid_q <= ifid_d;
            idex_q <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    // Register file write-back; x0 never written
    always_ff @(posedge clk) begin
        if (!r) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (memwb_q.wen && memwb_q.rd != 5'd0) begin
            rf_q[memwb_q.rd] <= memwb_q.res;
        end
    end

    // Data memory store port; contents survive reset
    always_ff @(posedge clk) begin
        if (r && exmem_q.st) dmem[exmem_q.res[DW+1:2]] <= exmem_q.sd;
    end

    // Instruction memory load port, active regardless of reset
    always_ff @(posedge clk) begin
        if (i_mem_write) imem[i_mem_addr[IW+1:2]] <= i_mem_data;
    end
endmodule

// File: tb/tb_riscv_cpu_core.sv
// tb_riscv_cpu_core: directed program run, mid-run reset
// and re-execution against hand-computed register values.
module tb_riscv_cpu_core;
    logic        clk = 1'b0;
    logic        r;
    logic        i_mem_write;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_data;
    logic [4:0]  dbg_reg_addr;
    logic [31:0] dbg_reg_data;
    logic [31:0] pc_out;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    riscv_cpu_core dut (
        .clk(clk),
        .r(r),
        .i_mem_write(i_mem_write),
        .i_mem_addr(i_mem_addr),
        .i_mem_data(i_mem_data),
        .dbg_reg_addr(dbg_reg_addr),
        .dbg_reg_data(dbg_reg_data),
        .pc_out(pc_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    logic [31:0] prog [23];
    logic [4:0]  e_idx [19];
    logic [31:0] e_val [19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input logic [4:0] idx, output logic [31:0] v);
        dbg_reg_addr = idx;
        #1;
        v = dbg_reg_data;
    endtask

    task automatic run(input int n, output int c24, output int c28);
        c24 = 0;
        c28 = 0;
        repeat (n) begin
            tick();
            if (pc_out == 32'h24) c24++;
            if (pc_out == 32'h28) c28++;
        end
    endtask

    task automatic check_regs(input string pfx);
        logic [31:0] v;
        for (int i = 0; i < 19; i++) begin
            rd_reg(e_idx[i], v);
            chk($sformatf("%s_x%0d", pfx, e_idx[i]), v, e_val[i]);
        end
    endtask

    initial begin
        int c24, c28;
        logic [31:0] v;
        localparam logic [6:0] OPI = 7'b0010011;
        prog[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
        prog[1]  = enc_i(12'd7, 5'd0, 3'b000, 5'd2, OPI);
        prog[2]  = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);
        prog[3]  = enc_i(12'hfff, 5'd0, 3'b000, 5'd10, OPI);
        prog[4]  = enc_i(12'd0, 5'd0, 3'b000, 5'd0, OPI);
        prog[5]  = enc_r(7'h20, 5'd10, 5'd0, 3'b000, 5'd11);
        prog[6]  = enc_r(7'd0, 5'd10, 5'd0, 3'b011, 5'd4);
        prog[7]  = enc_s(12'd0, 5'd3, 5'd0);
        prog[8]  = enc_i(12'd0, 5'd0, 3'b010, 5'd5, 7'b0000011);
        prog[9]  = enc_i(12'd1, 5'd5, 3'b000, 5'd6, OPI);
        prog[10] = enc_b(13'd12, 5'd1, 5'd1, 3'b000);
        prog[11] = enc_i(12'd9, 5'd0, 3'b000, 5'd7, OPI);
        prog[12] = enc_i(12'd9, 5'd0, 3'b000, 5'd7, OPI);
        prog[13] = enc_j(21'd8, 5'd8);
        prog[14] = enc_i(12'd1, 5'd0, 3'b000, 5'd12, OPI);
        prog[15] = enc_i(12'd3, 5'd0, 3'b000, 5'd0, OPI);
        prog[16] = {20'hABCDE, 5'd9, 7'b0110111};
        prog[17] = enc_i(12'h051, 5'd0, 3'b000, 5'd14, OPI);
        prog[18] = enc_i(12'd0, 5'd14, 3'b000, 5'd13, 7'b1100111);
        prog[19] = enc_i(12'd1, 5'd0, 3'b000, 5'd15, OPI);
        prog[20] = enc_i(12'h404, 5'd10, 3'b101, 5'd16, OPI);
        prog[21] = enc_r(7'd0, 5'd0, 5'd10, 3'b010, 5'd17);
        prog[22] = enc_j(21'd0, 5'd0);

        e_idx[0]  = 5'd1;  e_val[0]  = 32'd5;
        e_idx[1]  = 5'd2;  e_val[1]  = 32'd7;
        e_idx[2]  = 5'd3;  e_val[2]  = 32'd12;
        e_idx[3]  = 5'd10; e_val[3]  = 32'hffffffff;
        e_idx[4]  = 5'd11; e_val[4]  = 32'd1;
        e_idx[5]  = 5'd4;  e_val[5]  = 32'd1;
        e_idx[6]  = 5'd5;  e_val[6]  = 32'd12;
        e_idx[7]  = 5'd6;  e_val[7]  = 32'd13;
        e_idx[8]  = 5'd7;  e_val[8]  = 32'd0;
        e_idx[9]  = 5'd8;  e_val[9]  = 32'h38;
        e_idx[10] = 5'd12; e_val[10] = 32'd0;
        e_idx[11] = 5'd0;  e_val[11] = 32'd0;
        e_idx[12] = 5'd9;  e_val[12] = 32'hABCDE000;
        e_idx[13] = 5'd14; e_val[13] = 32'h51;
        e_idx[14] = 5'd13; e_val[14] = 32'h4c;
        e_idx[15] = 5'd15; e_val[15] = 32'd0;
        e_idx[16] = 5'd16; e_val[16] = 32'hffffffff;
        e_idx[17] = 5'd17; e_val[17] = 32'd1;
        e_idx[18] = 5'd31; e_val[18] = 32'd0;

        r = 1'b0;
        i_mem_write = 1'b0;
        i_mem_addr = 32'd0;
        i_mem_data = 32'd0;
        dbg_reg_addr = 5'd0;
        tick();
        for (int i = 0; i < 23; i++) begin
            i_mem_write = 1'b1;
            i_mem_addr = 32'(i * 4);
            i_mem_data = prog[i];
            tick();
        end
        i_mem_write = 1'b0;
        tick();
        chk("rst_pc", pc_out, 32'd0);
        rd_reg(5'd1, v);
        chk("rst_x1", v, 32'd0);

        r = 1'b1;
        tick();
        chk("pc_step", pc_out, 32'd4);
        run(59, c24, c28);
        chk("stall_pc24", 32'(c24), 32'd1);
        chk("stall_pc28", 32'(c28), 32'd2);
        check_regs("run1");

        r = 1'b0;
        tick();
        r = 1'b1;
        chk("midrst_pc", pc_out, 32'd0);
        rd_reg(5'd3, v);
        chk("midrst_x3", v, 32'd0);
        rd_reg(5'd9, v);
        chk("midrst_x9", v, 32'd0);
        tick();
        chk("pc_step2", pc_out, 32'd4);
        run(59, c24, c28);
        chk("stall2_pc24", 32'(c24), 32'd1);
        chk("stall2_pc28", 32'(c28), 32'd2);
        check_regs("run2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
